ram_arbiter: RTL and testbench

//  Shares the single-port data RAM between the CPU load/store path and one auxiliary master
//  (program loader / display reader). Per-cycle arbitration: CPU has fixed priority, plus an

---
 rtl/ram_arbiter_pkg.sv | 28 ++
 rtl/ram_arbiter_if.sv | 32 +++
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the data-RAM arbiter.
//   rd_owner_t  : owner of the read whose data returns next cycle
//   DEF_*       : default address/data widths and aux starvation limit
//   cnt_width() : bits needed to hold 0..limit for the starvation counter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_AW           = 32;
    localparam int DEF_DW           = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_CPU  = 2'd1,
        R_AUX  = 2'd2
    } rd_owner_t;

    // A limit below 1 is meaningless; clamp so the counter is never zero-width.
    function automatic int cnt_width(input int limit);
        if (limit < 1) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// One requester's access port onto the shared data RAM.
//   req/we/addr/wdata : request, held stable by the master until gnt=1
//   gnt               : access issued to the RAM this cycle
//   rvalid/rdata      : read data, one cycle after a granted read; rdata=0 otherwise
// Modports: master (the CPU or aux side), slave (the arbiter side).
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single-port data RAM between the CPU load/store path and one
// auxiliary master (program loader / display reader). The CPU has fixed
// priority; an aux request denied STARVE_LIMIT cycles in a row is forced
// through on the next cycle. Read data (1-cycle RAM latency) is steered back
// to whichever master issued the read.
//
// Ports
//   clk        : clock, all state on rising edge
//   reset      : asynchronous, active-high; all outputs 0 while asserted
//   cpu        : CPU access port (slave side)
//   aux        : aux access port (slave side)
//   cpu_stall  : cpu.req & ~cpu.gnt, CPU holds PC and request
//   mem_addr   : RAM address   (0 when nothing granted)
//   mem_wdata  : RAM write data (0 when nothing granted)
//   mem_we     : RAM write enable
//   mem_rdata  : RAM read data, valid one cycle after a read is issued
//
// Read-return FSM (rd_state_q)
//   state  | meaning
//   R_NONE | no read issued last cycle, both rvalid low
//   R_CPU  | CPU read issued last cycle, mem_rdata belongs to CPU
//   R_AUX  | aux read issued last cycle, mem_rdata belongs to aux
// ---------------------------------------------------------------------------
module ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic           clk,
    input  logic           reset,
    ram_arbiter_if.slave   cpu,
    ram_arbiter_if.slave   aux,
    output logic           cpu_stall,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic           mem_we,
    input  logic [DW-1:0]  mem_rdata
);

    localparam int            CW      = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    rd_owner_t     rd_state_q, rd_state_d;

    logic force_aux;
    logic cpu_gnt;
    logic aux_gnt;
    logic cpu_rvalid;
    logic aux_rvalid;

    // Grants are gated by reset so nothing reaches the RAM while reset is held,
    // even though the request inputs themselves are not reset.
    always_comb begin
        force_aux = aux.req & (starve_cnt_q == LIMIT_C);
        aux_gnt   = ~reset & aux.req & (force_aux | ~cpu.req);
        cpu_gnt   = ~reset & cpu.req & ~aux_gnt;
    end

    assign cpu.gnt   = cpu_gnt;
    assign aux.gnt   = aux_gnt;
    assign cpu_stall = ~reset & cpu.req & ~cpu_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu.we;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
        end else if (aux_gnt) begin
            mem_we    = aux.we;
            mem_addr  = aux.addr;
            mem_wdata = aux.wdata;
        end
    end

    // Counts consecutive denied aux cycles; a dropped request forgets its history.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (aux_gnt || !aux.req) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rd_state_d = R_NONE;
        if (cpu_gnt && !cpu.we) begin
            rd_state_d = R_CPU;
        end else if (aux_gnt && !aux.we) begin
            rd_state_d = R_AUX;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            rd_state_q   <= R_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_state_q   <= rd_state_d;
        end
    end

    assign cpu_rvalid = (rd_state_q == R_CPU);
    assign aux_rvalid = (rd_state_q == R_AUX);

    assign cpu.rvalid = cpu_rvalid;
    assign aux.rvalid = aux_rvalid;
    assign cpu.rdata  = cpu_rvalid ? mem_rdata : '0;
    assign aux.rdata  = aux_rvalid ? mem_rdata : '0;

    a_one_owner : assert property (@(posedge clk) disable iff (reset)
        !(cpu_gnt && aux_gnt));

    a_cnt_bound : assert property (@(posedge clk) disable iff (reset)
        starve_cnt_q <= LIMIT_C);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    ram_arbiter_if #(.AW(32), .DW(32)) cpu_if ();
    ram_arbiter_if #(.AW(32), .DW(32)) aux_if ();

    ram_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (cpu_if),
        .aux       (aux_if),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM, 1-cycle read latency.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[7:2]];
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_denied;   // consecutive cycles aux has asked and been refused
    int          m_pend;     // 0 none, 1 cpu, 2 aux: read returning next cycle
    logic [31:0] m_pdata;
    logic [31:0] mm [64];

    logic        e_cgnt, e_agnt, e_stall, e_crv, e_arv, e_mwe;
    logic [31:0] e_crd, e_ard, e_maddr, e_mwd;

    task automatic model_eval();
        // Aux wins when the CPU is idle or aux has waited out its allowance.
        e_agnt  = aux_if.req && (!cpu_if.req || m_denied >= LIMIT);
        e_cgnt  = cpu_if.req && !e_agnt;
        e_stall = cpu_if.req && !e_cgnt;
        e_mwe   = 1'b0; e_maddr = '0; e_mwd = '0;
        if (e_cgnt) begin
            e_mwe = cpu_if.we; e_maddr = cpu_if.addr; e_mwd = cpu_if.wdata;
        end
        if (e_agnt) begin
            e_mwe = aux_if.we; e_maddr = aux_if.addr; e_mwd = aux_if.wdata;
        end
        e_crv = (m_pend == 1);
        e_arv = (m_pend == 2);
        e_crd = e_crv ? m_pdata : 32'h0;
        e_ard = e_arv ? m_pdata : 32'h0;
    endtask

    task automatic model_commit();
        if (e_agnt || !aux_if.req) m_denied = 0;
        else if (m_denied < LIMIT) m_denied++;
        m_pend = 0;
        if ((e_cgnt || e_agnt) && !e_mwe) begin
            m_pend  = e_cgnt ? 1 : 2;
            m_pdata = mm[e_maddr[7:2]];
        end
        if (e_mwe) mm[e_maddr[7:2]] = e_mwd;
    endtask

    task automatic check_model();
        chk1 ("cpu_gnt",    cpu_if.gnt,    e_cgnt);
        chk1 ("aux_gnt",    aux_if.gnt,    e_agnt);
        chk1 ("cpu_stall",  cpu_stall,     e_stall);
        chk1 ("cpu_rvalid", cpu_if.rvalid, e_crv);
        chk32("cpu_rdata",  cpu_if.rdata,  e_crd);
        chk1 ("aux_rvalid", aux_if.rvalid, e_arv);
        chk32("aux_rdata",  aux_if.rdata,  e_ard);
        chk1 ("mem_we",     mem_we,        e_mwe);
        chk32("mem_addr",   mem_addr,      e_maddr);
        chk32("mem_wdata",  mem_wdata,     e_mwd);
    endtask

    task automatic check_all_zero(input string tag);
        chk1 ({tag, " cpu_gnt"},    cpu_if.gnt,    1'b0);
        chk1 ({tag, " aux_gnt"},    aux_if.gnt,    1'b0);
        chk1 ({tag, " cpu_stall"},  cpu_stall,     1'b0);
        chk1 ({tag, " cpu_rvalid"}, cpu_if.rvalid, 1'b0);
        chk32({tag, " cpu_rdata"},  cpu_if.rdata,  32'h0);
        chk1 ({tag, " aux_rvalid"}, aux_if.rvalid, 1'b0);
        chk32({tag, " aux_rdata"},  aux_if.rdata,  32'h0);
        chk1 ({tag, " mem_we"},     mem_we,        1'b0);
        chk32({tag, " mem_addr"},   mem_addr,      32'h0);
        chk32({tag, " mem_wdata"},  mem_wdata,     32'h0);
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [31:0] cwd, input logic areq, input logic awe,
                         input logic [31:0] aaddr, input logic [31:0] awd);
        cpu_if.req = creq; cpu_if.we = cwe; cpu_if.addr = caddr; cpu_if.wdata = cwd;
        aux_if.req = areq; aux_if.we = awe; aux_if.addr = aaddr; aux_if.wdata = awd;
    endtask

    // Called at posedge+1: settle, evaluate model; caller checks; then end_cycle.
    task automatic mid_cycle();
        #4;
        model_eval();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic model_reset();
        m_denied = 0;
        m_pend   = 0;
        m_pdata  = '0;
    endtask

    // Reset with both masters requesting: every output must read 0.
    task automatic do_reset(input string tag);
        drive(1'b1, 1'b1, 32'h24, 32'h5555_AAAA, 1'b1, 1'b1, 32'h28, 32'h1234_5678);
        reset = 1'b1;
        model_reset();
        #1;
        check_all_zero(tag);
        @(posedge clk); #1;
        @(posedge clk); #4;
        check_all_zero(tag);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        creq, cwe;
        logic [31:0] caddr, cwd;
        logic        areq, awe;
        logic [31:0] aaddr, awd;
        logic        e_cgnt, e_agnt, e_stall, e_crv;
        logic [31:0] e_crd;
        logic        e_arv;
        logic [31:0] e_ard;
        logic        e_mwe;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t vecs [11];

    logic        c_act, a_act;
    logic        r_cwe, r_awe;
    logic [31:0] r_caddr, r_cwd, r_aaddr, r_awd;
    logic        exp_aux;

    initial begin
        //            creq  cwe   caddr     cwd            areq  awe   aaddr     awd            cgnt  agnt  stall crv   crd            arv   ard            mwe   maddr
        vecs[0]  = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h10};
        vecs[1]  = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h10};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF,  1'b0, 32'h0,         1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h20, 32'hA5A50020,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h20};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h20};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hA5A50020,  1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 32'h4,  32'h11110004, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h8,  32'h22220008,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8};
        vecs[8]  = '{1'b1, 1'b0, 32'h4,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h4};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h8,  32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h11110004,  1'b0, 32'h0,         1'b0, 32'h8};
        vecs[10] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h22220008,  1'b0, 32'h0};

        for (int i = 0; i < 64; i++) begin
            ram[i] = '0;
            mm[i]  = '0;
        end
        model_reset();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset while a CPU read is in flight: the data must never return.
        drive(1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, '0, '0);
        mid_cycle();
        chk1("mid_read cpu_gnt", cpu_if.gnt, 1'b1);
        @(posedge clk); #1;
        do_reset("reset_mid_read");
        mid_cycle();
        chk1("post_reset cpu_rvalid", cpu_if.rvalid, 1'b0);
        chk1("post_reset aux_rvalid", aux_if.rvalid, 1'b0);
        end_cycle();

        // Directed vectors: CPU write/read, aux-only access, back-to-back owners.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].areq, vecs[i].awe, vecs[i].aaddr, vecs[i].awd);
            mid_cycle();
            chk1 ($sformatf("vec%0d cpu_gnt", i),    cpu_if.gnt,    vecs[i].e_cgnt);
            chk1 ($sformatf("vec%0d aux_gnt", i),    aux_if.gnt,    vecs[i].e_agnt);
            chk1 ($sformatf("vec%0d cpu_stall", i),  cpu_stall,     vecs[i].e_stall);
            chk1 ($sformatf("vec%0d cpu_rvalid", i), cpu_if.rvalid, vecs[i].e_crv);
            chk32($sformatf("vec%0d cpu_rdata", i),  cpu_if.rdata,  vecs[i].e_crd);
            chk1 ($sformatf("vec%0d aux_rvalid", i), aux_if.rvalid, vecs[i].e_arv);
            chk32($sformatf("vec%0d aux_rdata", i),  aux_if.rdata,  vecs[i].e_ard);
            chk1 ($sformatf("vec%0d mem_we", i),     mem_we,        vecs[i].e_mwe);
            chk32($sformatf("vec%0d mem_addr", i),   mem_addr,      vecs[i].e_maddr);
            end_cycle();
        end

        // Both masters requesting continuously: aux gets every 5th cycle.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 32'h40 + 32'(4 * (i % 4)), '0, 1'b1, 1'b0, 32'h80, '0);
            mid_cycle();
            exp_aux = ((i % 5) == 4);
            chk1($sformatf("contend%0d aux_gnt", i),   aux_if.gnt, exp_aux);
            chk1($sformatf("contend%0d cpu_stall", i), cpu_stall,  exp_aux);
            check_model();
            end_cycle();
        end

        // Aux drops after 3 denials, reasserts: needs 4 fresh denials again.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 32'h44, '0, (i != 3), 1'b0, 32'h84, '0);
            mid_cycle();
            exp_aux = (i == 8);
            chk1($sformatf("drop%0d aux_gnt", i), aux_if.gnt, exp_aux);
            chk1($sformatf("drop%0d cpu_gnt", i), cpu_if.gnt, !exp_aux);
            check_model();
            end_cycle();
        end

        // Randomized traffic, masters hold requests until granted; aux may give up.
        c_act = 1'b0; a_act = 1'b0;
        r_cwe = 1'b0; r_awe = 1'b0;
        r_caddr = '0; r_cwd = '0; r_aaddr = '0; r_awd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) begin
                do_reset("reset_random");
                c_act = 1'b0; a_act = 1'b0;
            end
            if (!c_act && ($urandom_range(2) != 0)) begin
                c_act   = 1'b1;
                r_cwe   = 1'($urandom_range(1));
                r_caddr = 32'($urandom_range(15)) << 2;
                r_cwd   = $urandom;
            end
            if (a_act && ($urandom_range(7) == 0)) begin
                a_act = 1'b0;
            end else if (!a_act && ($urandom_range(3) != 0)) begin
                a_act   = 1'b1;
                r_awe   = 1'($urandom_range(1));
                r_aaddr = 32'($urandom_range(15)) << 2;
                r_awd   = $urandom;
            end
            drive(c_act, r_cwe, r_caddr, r_cwd, a_act, r_awe, r_aaddr, r_awd);
            mid_cycle();
            check_model();
            end_cycle();
            if (e_cgnt) c_act = 1'b0;
            if (e_agnt) a_act = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
